// File: rtl/prog_sequencer.sv
// Program FIFO and step-clock generator for the 10-bit processor.
// Define PROG_SEQ_LOOP_EN to recycle popped words so the program repeats.
module prog_sequencer #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned STEP_DIV = 5_000_000,
    parameter int unsigned PULSE_W  = 4
) (
    input  logic                       CLK50M,
    input  logic                       RSTn,
    input  logic [9:0]                 SW,
    input  logic                       load,
    input  logic                       step,
    input  logic                       run,
    input  logic                       done,
    output logic [9:0]                 D,
    output logic                       CLK_STEP,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       halt,
    output logic                       ovf
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned DIV_W = $clog2(STEP_DIV + 1);
    localparam int unsigned PW_W  = $clog2(PULSE_W + 1);

    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(STEP_DIV - 1);
    localparam logic [PW_W-1:0]  PW_LAST   = PW_W'(PULSE_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PULSE,
        S_HALT
    } state_e;

    logic [2:0]       load_sync_q, step_sync_q, done_sync_q;
    logic             load_ev, step_ev, done_ev;

    logic [9:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             ovf_q, ovf_d;
    logic             push, pop, drain;

    state_e           state_q, ret_q;
    logic [DIV_W-1:0] div_q;
    logic [PW_W-1:0]  pw_q;
    logic             clk_step_q;
    logic             halt_q;

    // Bits [1:0] synchronize; bit 2 holds the previous synchronized level.
    always_ff @(posedge CLK50M or negedge RSTn) begin
        if (!RSTn) begin
            load_sync_q <= '0;
            step_sync_q <= '0;
            done_sync_q <= '0;
        end else begin
            load_sync_q <= {load_sync_q[1:0], load};
            step_sync_q <= {step_sync_q[1:0], step};
            done_sync_q <= {done_sync_q[1:0], done};
        end
    end

    assign load_ev = load_sync_q[1] & ~load_sync_q[2];
    assign step_ev = step_sync_q[1] & ~step_sync_q[2];
    assign done_ev = done_sync_q[1] & ~done_sync_q[2];

    always_comb begin
        push     = load_ev && !full_q;
        pop      = done_ev && !empty_q;
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q;
        drain    = 1'b0;
`ifdef PROG_SEQ_LOOP_EN
        wr_ptr_d = wr_ptr_q + PTR_W'(push) + PTR_W'(pop);
        if (push) begin
            count_d = count_q + CNT_W'(1);
        end
`else
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
        drain = pop && !push && (count_q == CNT_W'(1));
`endif
        full_d  = (count_d == CNT_DEPTH);
        empty_d = (count_d == '0);
        ovf_d   = ovf_q | (load_ev & full_q);
    end

    always_ff @(posedge CLK50M or negedge RSTn) begin
        if (!RSTn) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
        end
    end

`ifdef PROG_SEQ_LOOP_EN
    logic [PTR_W-1:0] wr_nxt;
    assign wr_nxt = wr_ptr_q + PTR_W'(1);

    // On a simultaneous load, the recycled word lands first and the new word right after it.
    always_ff @(posedge CLK50M) begin
        if (pop) begin
            mem_q[wr_ptr_q] <= mem_q[rd_ptr_q];
            if (push) begin
                mem_q[wr_nxt] <= SW;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= SW;
        end
    end
`else
    always_ff @(posedge CLK50M) begin
        if (push) begin
            mem_q[wr_ptr_q] <= SW;
        end
    end
`endif

    always_comb begin
        D = empty_q ? '0 : mem_q[rd_ptr_q];
    end

    always_ff @(posedge CLK50M or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= S_IDLE;
            ret_q      <= S_IDLE;
            div_q      <= '0;
            pw_q       <= '0;
            clk_step_q <= 1'b0;
            halt_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (step_ev) begin
                        state_q    <= S_PULSE;
                        ret_q      <= S_IDLE;
                        pw_q       <= '0;
                        clk_step_q <= 1'b1;
                    end else if (run && !empty_q) begin
                        state_q <= S_RUN;
                        div_q   <= '0;
`ifdef PROG_SEQ_LOOP_EN
                    end else if (run) begin
                        state_q <= S_HALT;
                        halt_q  <= 1'b1;
`endif
                    end
                end
                S_RUN: begin
                    if (!run) begin
                        state_q <= S_IDLE;
                    end else if (drain) begin
                        state_q <= S_HALT;
                        halt_q  <= 1'b1;
                    end else if (div_q == DIV_LAST) begin
                        state_q    <= S_PULSE;
                        ret_q      <= S_RUN;
                        pw_q       <= '0;
                        div_q      <= '0;
                        clk_step_q <= 1'b1;
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end
                S_PULSE: begin
                    if (pw_q == PW_LAST) begin
                        clk_step_q <= 1'b0;
                        div_q      <= '0;
                        state_q    <= (ret_q == S_RUN && run) ? S_RUN : S_IDLE;
                    end else begin
                        pw_q <= pw_q + PW_W'(1);
                    end
                end
                S_HALT: begin
                    if (!run) begin
                        state_q <= S_IDLE;
                        halt_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign CLK_STEP = clk_step_q;
    assign count    = count_q;
    assign full     = full_q;
    assign empty    = empty_q;
    assign halt     = halt_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed self-checking bench for prog_sequencer (DEPTH=4, STEP_DIV=8, PULSE_W=4).
module tb_prog_sequencer;

    localparam int unsigned DEPTH    = 4;
    localparam int unsigned STEP_DIV = 8;
    localparam int unsigned PULSE_W  = 4;

    logic       CLK50M;
    logic       RSTn;
    logic [9:0] SW;
    logic       load, step, run, done;
    logic [9:0] D;
    logic       CLK_STEP;
    logic [2:0] count;
    logic       full, empty, halt, ovf;

    int errs   = 0;
    int checks = 0;

    prog_sequencer #(
        .DEPTH    (DEPTH),
        .STEP_DIV (STEP_DIV),
        .PULSE_W  (PULSE_W)
    ) dut (
        .CLK50M   (CLK50M),
        .RSTn     (RSTn),
        .SW       (SW),
        .load     (load),
        .step     (step),
        .run      (run),
        .done     (done),
        .D        (D),
        .CLK_STEP (CLK_STEP),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .halt     (halt),
        .ovf      (ovf)
    );

    initial CLK50M = 1'b0;
    always #5 CLK50M = ~CLK50M;

    task automatic apply_reset();
        load = 0; step = 0; run = 0; done = 0; SW = '0;
        RSTn = 1'b0;
        repeat (2) @(posedge CLK50M);
        @(negedge CLK50M);
        RSTn = 1'b1;
        @(negedge CLK50M);
    endtask

    // Raises the selected buttons; returns 1ns after the third rising edge.
    task automatic press(input logic l, input logic d, input logic s, input logic [9:0] w);
        @(negedge CLK50M);
        SW = w; load = l; done = d; step = s;
        repeat (3) @(posedge CLK50M);
        #1;
    endtask

    task automatic release_btns();
        @(negedge CLK50M);
        load = 0; done = 0; step = 0;
        repeat (3) @(negedge CLK50M);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (D !== 10'h000)  begin errs++; $display("FAIL rst_D: got %h expected 000", D); end
        checks++; if (CLK_STEP !== 1'b0) begin errs++; $display("FAIL rst_clk: got %b expected 0", CLK_STEP); end
        checks++; if (count !== 3'd0) begin errs++; $display("FAIL rst_count: got %0d expected 0", count); end
        checks++; if (empty !== 1'b1) begin errs++; $display("FAIL rst_empty: got %b expected 1", empty); end
        checks++; if (full !== 1'b0)  begin errs++; $display("FAIL rst_full: got %b expected 0", full); end
        checks++; if (halt !== 1'b0)  begin errs++; $display("FAIL rst_halt: got %b expected 0", halt); end
        checks++; if (ovf !== 1'b0)   begin errs++; $display("FAIL rst_ovf: got %b expected 0", ovf); end
    endtask

    task automatic test_load();
        apply_reset();
        @(negedge CLK50M);
        SW = 10'h2A1; load = 1;
        repeat (2) @(posedge CLK50M);
        #1;
        checks++; if (count !== 3'd0) begin errs++; $display("FAIL load_latency2: got %0d expected 0", count); end
        @(posedge CLK50M);
        #1;
        checks++; if (count !== 3'd1) begin errs++; $display("FAIL load_latency3: got %0d expected 1", count); end
        checks++; if (D !== 10'h2A1) begin errs++; $display("FAIL load_first_D: got %h expected 2a1", D); end
        release_btns();
        press(1, 0, 0, 10'h055); release_btns();
        press(1, 0, 0, 10'h3FF); release_btns();
        checks++; if (count !== 3'd3) begin errs++; $display("FAIL load_count3: got %0d expected 3", count); end
        checks++; if (D !== 10'h2A1) begin errs++; $display("FAIL load_D_head: got %h expected 2a1", D); end
        checks++; if (empty !== 1'b0) begin errs++; $display("FAIL load_empty: got %b expected 0", empty); end
`ifndef PROG_SEQ_LOOP_EN
        press(0, 1, 0, 10'h000);
        checks++; if (D !== 10'h055) begin errs++; $display("FAIL pop1_D: got %h expected 055", D); end
        checks++; if (count !== 3'd2) begin errs++; $display("FAIL pop1_count: got %0d expected 2", count); end
        release_btns();
        press(0, 1, 0, 10'h000); release_btns();
        checks++; if (D !== 10'h3FF) begin errs++; $display("FAIL pop2_D: got %h expected 3ff", D); end
        press(0, 1, 0, 10'h000); release_btns();
        checks++; if (D !== 10'h000) begin errs++; $display("FAIL pop3_D: got %h expected 000", D); end
        checks++; if (empty !== 1'b1) begin errs++; $display("FAIL pop3_empty: got %b expected 1", empty); end
        press(0, 1, 0, 10'h000); release_btns();
        checks++; if (count !== 3'd0) begin errs++; $display("FAIL pop_on_empty: got %0d expected 0", count); end
`endif
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 0; i <= int'(DEPTH); i++) begin
            press(1, 0, 0, 10'(10'h100 + i));
            release_btns();
            if (i == int'(DEPTH) - 1) begin
                checks++; if (full !== 1'b1) begin errs++; $display("FAIL ovf_full_at_depth: got %b expected 1", full); end
                checks++; if (ovf !== 1'b0)  begin errs++; $display("FAIL ovf_early: got %b expected 0", ovf); end
            end
        end
        checks++; if (full !== 1'b1)  begin errs++; $display("FAIL ovf_full: got %b expected 1", full); end
        checks++; if (count !== 3'd4) begin errs++; $display("FAIL ovf_count: got %0d expected 4", count); end
        checks++; if (ovf !== 1'b1)   begin errs++; $display("FAIL ovf_flag: got %b expected 1", ovf); end
        for (int i = 0; i < int'(DEPTH); i++) begin
            checks++;
            if (D !== 10'(10'h100 + i)) begin
                errs++; $display("FAIL ovf_drain_D%0d: got %h expected %h", i, D, 10'(10'h100 + i));
            end
            press(0, 1, 0, 10'h000);
            release_btns();
        end
        checks++; if (D !== 10'h000)  begin errs++; $display("FAIL ovf_last_absent: got %h expected 000", D); end
        checks++; if (empty !== 1'b1) begin errs++; $display("FAIL ovf_drained_empty: got %b expected 1", empty); end
    endtask

    task automatic test_step();
        int highs;
        apply_reset();
        highs = 0;
        @(negedge CLK50M);
        step = 1;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            @(posedge CLK50M);
            #1;
            if (CLK_STEP === 1'b1) highs++;
            if (cyc == 2) begin
                checks++; if (CLK_STEP !== 1'b0) begin errs++; $display("FAIL step_edge2: got %b expected 0", CLK_STEP); end
            end
            if (cyc == 3) begin
                checks++; if (CLK_STEP !== 1'b1) begin errs++; $display("FAIL step_edge3: got %b expected 1", CLK_STEP); end
                step = 0;
            end
            if (cyc == 4) step = 1;
            if (cyc == 7) begin
                checks++; if (CLK_STEP !== 1'b0) begin errs++; $display("FAIL step_fall: got %b expected 0", CLK_STEP); end
            end
        end
        checks++; if (highs != int'(PULSE_W)) begin errs++; $display("FAIL step_high_cycles: got %0d expected %0d", highs, PULSE_W); end
        release_btns();
    endtask

    task automatic test_run();
        int nrise, rise1, rise2;
        logic prev;
        apply_reset();
        press(1, 0, 0, 10'h111); release_btns();
        press(1, 0, 0, 10'h222); release_btns();
        nrise = 0; rise1 = 0; rise2 = 0; prev = 1'b0;
        @(negedge CLK50M);
        run = 1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge CLK50M);
            #1;
            if (CLK_STEP === 1'b1 && prev === 1'b0) begin
                nrise++;
                if (nrise == 1) rise1 = cyc;
                if (nrise == 2) rise2 = cyc;
            end
            prev = CLK_STEP;
            if (cyc == 9) begin
                checks++; if (CLK_STEP !== 1'b1) begin errs++; $display("FAIL run_first_rise: got %b expected 1", CLK_STEP); end
                checks++; if (D !== 10'h111) begin errs++; $display("FAIL run_D0: got %h expected 111", D); end
            end
            if (cyc == 17) begin
                checks++; if (D !== 10'h222) begin errs++; $display("FAIL run_D1: got %h expected 222", D); end
                checks++; if (count !== 3'd1) begin errs++; $display("FAIL run_count1: got %0d expected 1", count); end
            end
            if (cyc == 28) begin
                checks++; if (halt !== 1'b0) begin errs++; $display("FAIL run_halt_early: got %b expected 0", halt); end
            end
            if (cyc == 29) begin
                checks++; if (halt !== 1'b1) begin errs++; $display("FAIL run_halt: got %b expected 1", halt); end
                checks++; if (D !== 10'h000) begin errs++; $display("FAIL run_halt_D: got %h expected 000", D); end
                checks++; if (empty !== 1'b1) begin errs++; $display("FAIL run_halt_empty: got %b expected 1", empty); end
            end
            if (cyc == 14 || cyc == 26) done = 1;
            if (cyc == 18 || cyc == 30) done = 0;
        end
        checks++; if (nrise != 2) begin errs++; $display("FAIL run_rises: got %0d expected 2", nrise); end
        checks++; if (rise2 - rise1 != 12) begin errs++; $display("FAIL run_period: got %0d expected 12", rise2 - rise1); end
        checks++; if (halt !== 1'b1) begin errs++; $display("FAIL run_halt_hold: got %b expected 1", halt); end
        @(negedge CLK50M);
        run = 0;
        @(posedge CLK50M);
        #1;
        checks++; if (halt !== 1'b0) begin errs++; $display("FAIL run_drop_idle: got %b expected 0", halt); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        press(1, 0, 0, 10'h0AA); release_btns();
        press(1, 1, 0, 10'h0BB);
`ifdef PROG_SEQ_LOOP_EN
        checks++; if (count !== 3'd2) begin errs++; $display("FAIL b2b_count: got %0d expected 2", count); end
        checks++; if (D !== 10'h0AA) begin errs++; $display("FAIL b2b_D: got %h expected 0aa", D); end
`else
        checks++; if (count !== 3'd1) begin errs++; $display("FAIL b2b_count: got %0d expected 1", count); end
        checks++; if (D !== 10'h0BB) begin errs++; $display("FAIL b2b_D: got %h expected 0bb", D); end
`endif
        release_btns();
    endtask

    task automatic test_reset_mid_pulse();
        press(1, 0, 0, 10'h155); release_btns();
        checks++; if (count === 3'd0) begin errs++; $display("FAIL rmp_preload: got %0d expected nonzero", count); end
        press(0, 0, 1, 10'h155);
        checks++; if (CLK_STEP !== 1'b1) begin errs++; $display("FAIL rmp_pulse: got %b expected 1", CLK_STEP); end
        #2;
        RSTn = 1'b0;
        step = 0;
        #1;
        checks++; if (CLK_STEP !== 1'b0) begin errs++; $display("FAIL rmp_clk: got %b expected 0", CLK_STEP); end
        checks++; if (count !== 3'd0) begin errs++; $display("FAIL rmp_count: got %0d expected 0", count); end
        checks++; if (D !== 10'h000)  begin errs++; $display("FAIL rmp_D: got %h expected 000", D); end
        checks++; if (empty !== 1'b1) begin errs++; $display("FAIL rmp_empty: got %b expected 1", empty); end
        checks++; if (ovf !== 1'b0)   begin errs++; $display("FAIL rmp_ovf: got %b expected 0", ovf); end
        checks++; if (full !== 1'b0)  begin errs++; $display("FAIL rmp_full: got %b expected 0", full); end
        @(negedge CLK50M);
        RSTn = 1'b1;
        @(negedge CLK50M);
    endtask

    task automatic test_loop();
        logic [9:0] exp_d;
        apply_reset();
        press(1, 0, 0, 10'h1A5); release_btns();
        press(1, 0, 0, 10'h25A); release_btns();
        for (int k = 0; k < 4; k++) begin
            exp_d = (k % 2 == 0) ? 10'h1A5 : 10'h25A;
            checks++; if (D !== exp_d) begin errs++; $display("FAIL loop_D%0d: got %h expected %h", k, D, exp_d); end
            press(0, 1, 0, 10'h000);
            release_btns();
            checks++; if (count !== 3'd2) begin errs++; $display("FAIL loop_count%0d: got %0d expected 2", k, count); end
        end
        checks++; if (D !== 10'h1A5) begin errs++; $display("FAIL loop_wrap_D: got %h expected 1a5", D); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_step();
        test_back_to_back();
`ifdef PROG_SEQ_LOOP_EN
        test_loop();
`else
        test_overflow();
        test_reset_mid_pulse();
        test_run();
`endif
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
